// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings and
// byte-assembly geometry.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 2;

  typedef logic [1:0] ldr_state_t;

  localparam ldr_state_t LDR_IDLE  = 2'd0;
  localparam ldr_state_t LDR_LOAD  = 2'd1;
  localparam ldr_state_t LDR_WRITE = 2'd2;
  localparam ldr_state_t LDR_DONE  = 2'd3;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte inserter: each accepted byte lands in the lane picked by
// the running byte index; the word register holds between loads.
module byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int BPW = BYTES_PER_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      idx  <= '0;
    end else if (accept) begin
      word[{idx, 3'b000} +: 8] <= data;
      idx                      <= idx + 1'b1;
    end
  end

  // idx wraps to 0 naturally after the final lane
  assign last_byte = (idx == IDX_W'(BPW - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as 32-bit words starting at address 0,
// holding the core until the requested number of words has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int BYTES_PER_WORD = imem_loader_pkg::BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;

  ldr_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tgt;
  logic             xfer;
  logic             start_acc;
  logic             last_byte;

  assign in_ready  = (state == LDR_LOAD);
  assign mem_we    = (state == LDR_WRITE);
  assign done      = (state == LDR_DONE);
  assign cpu_hold  = (state != LDR_DONE);
  assign xfer      = in_valid & in_ready;
  assign start_acc = start & ((state == LDR_IDLE) | (state == LDR_DONE));

  byte_assembler #(.BPW(BYTES_PER_WORD)) u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_acc),
    .accept   (xfer),
    .data     (in_data),
    .word     (mem_wdata),
    .last_byte(last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LDR_IDLE;
      mem_addr <= '0;
      cnt      <= '0;
      tgt      <= '0;
    end else begin
      case (state)
        LDR_IDLE, LDR_DONE: begin
          if (start) begin
            // zero encodes a full-depth load
            tgt      <= (word_count == '0) ? {1'b1, {ADDR_W{1'b0}}} : word_count;
            mem_addr <= '0;
            cnt      <= '0;
            state    <= LDR_LOAD;
          end
        end
        LDR_LOAD: begin
          if (xfer && last_byte) state <= LDR_WRITE;
        end
        LDR_WRITE: begin
          if ((cnt + CNT_W'(1)) == tgt) begin
            state <= LDR_DONE;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            mem_addr <= mem_addr + 1'b1;
            state    <= LDR_LOAD;
          end
        end
        default: state <= LDR_IDLE;
      endcase
    end
  end

endmodule
